// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: synchronizes and qualifies the PLL lock status, pulses the
// PLL reset, then releases the core reset and, after a gap, the peripheral reset.
// Any loss of lock pulls every downstream reset low and restarts the sequence.
// Optional feature: define PLL_RESET_SEQ_WATCHDOG_EN to add a WAIT_LOCK timeout
// that re-pulses the PLL reset and sets a sticky lock_timeout flag.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES     = 8,
  parameter int LOCK_STABLE_CYCLES = 16,
  parameter int STAGE_GAP          = 4,
  parameter int LOCK_TIMEOUT       = 1024,
  parameter int CNT_W              = 8
) (
  input  logic             clk_in,
  input  logic             resetn,
  input  logic             locked,
  output logic             pll_rst_req,
  output logic             core_rst_n,
  output logic             periph_rst_n,
  output logic             ready,
  output logic [CNT_W-1:0] loss_count,
  output logic             lock_timeout
);

  localparam int MAX_AB     = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES
                                                                    : LOCK_STABLE_CYCLES;
  localparam int MAX_CYCLES = (MAX_AB > STAGE_GAP) ? MAX_AB : STAGE_GAP;
  localparam int SEQ_W      = $clog2(MAX_CYCLES + 1);

  // Counter values seen on the last cycle of each timed phase.
  localparam logic [SEQ_W-1:0] PLL_LAST    = SEQ_W'(PLL_RST_CYCLES - 1);
  localparam logic [SEQ_W-1:0] STABLE_LAST = SEQ_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [SEQ_W-1:0] GAP_LAST    = SEQ_W'(STAGE_GAP - 1);

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    REL_CORE  = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [SEQ_W-1:0] cnt;
  logic [SEQ_W-1:0] cnt_next;
  logic             locked_meta;
  logic             locked_s;
  logic             lock_lost;

`ifdef PLL_RESET_SEQ_WATCHDOG_EN
  localparam int              WD_W    = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(LOCK_TIMEOUT - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_expired;
`endif

  // Two-flop synchronizer bringing the asynchronous lock status into clk_in.
  always_ff @(posedge clk_in) begin
    if (!resetn) begin
      locked_meta <= 1'b0;
      locked_s    <= 1'b0;
    end else begin
      locked_meta <= locked;
      locked_s    <= locked_meta;
    end
  end

  // Next-state and shared phase counter; the counter restarts on every state change.
  always_comb begin
    next_state = state;
    lock_lost  = 1'b0;
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
    wd_expired = 1'b0;
`endif
    case (state)
      PLL_RST: begin
        if (cnt == PLL_LAST) next_state = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s && (cnt == STABLE_LAST)) begin
          next_state = REL_CORE;
        end
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
        else if (wd_cnt == WD_LAST) begin
          next_state = PLL_RST;
          wd_expired = 1'b1;
        end
`endif
      end
      REL_CORE: begin
        // Lock loss outranks the end of the stage gap.
        if (!locked_s) begin
          next_state = PLL_RST;
          lock_lost  = 1'b1;
        end else if (cnt == GAP_LAST) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (!locked_s) begin
          next_state = PLL_RST;
          lock_lost  = 1'b1;
        end
      end
      default: next_state = PLL_RST;
    endcase

    cnt_next = cnt;
    if (next_state != state) begin
      cnt_next = '0;
    end else begin
      case (state)
        PLL_RST, REL_CORE: cnt_next = cnt + 1'b1;
        WAIT_LOCK:         cnt_next = locked_s ? (cnt + 1'b1) : '0;
        default:           cnt_next = '0;
      endcase
    end
  end

  // State register plus outputs decoded from the next state so they move with it.
  always_ff @(posedge clk_in) begin
    if (!resetn) begin
      state        <= PLL_RST;
      cnt          <= '0;
      pll_rst_req  <= 1'b1;
      core_rst_n   <= 1'b0;
      periph_rst_n <= 1'b0;
      ready        <= 1'b0;
      loss_count   <= '0;
    end else begin
      state        <= next_state;
      cnt          <= cnt_next;
      pll_rst_req  <= (next_state == PLL_RST);
      core_rst_n   <= (next_state == REL_CORE) || (next_state == RUN);
      periph_rst_n <= (next_state == RUN);
      ready        <= (next_state == RUN);
      if (lock_lost && (loss_count != {CNT_W{1'b1}})) begin
        loss_count <= loss_count + 1'b1;
      end
    end
  end

`ifdef PLL_RESET_SEQ_WATCHDOG_EN
  // Watchdog measures time spent in WAIT_LOCK and latches a sticky expiry flag.
  always_ff @(posedge clk_in) begin
    if (!resetn) begin
      wd_cnt       <= '0;
      lock_timeout <= 1'b0;
    end else begin
      if ((state == WAIT_LOCK) && (next_state == WAIT_LOCK)) begin
        wd_cnt <= wd_cnt + 1'b1;
      end else begin
        wd_cnt <= '0;
      end
      if (wd_expired) begin
        lock_timeout <= 1'b1;
      end
    end
  end
`else
  // Without the watchdog the flag can never be set (the comparison is constant false).
  assign lock_timeout = (LOCK_TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed stimulus with a cycle-stamped expectation queue.
// Stimulus pushes the expected output snapshot for a given edge; a monitor on the
// falling clock edge pops and compares entries as their edge comes around.
module tb_pll_reset_sequencer;

  localparam int CNT_W  = 4;
  localparam int S_PLL  = 0;
  localparam int S_WAIT = 1;
  localparam int S_REL  = 2;
  localparam int S_RUN  = 3;

  typedef struct {
    int    cyc;
    logic  pll;
    logic  core;
    logic  periph;
    logic  rdy;
    int    lc;
    logic  lto;
    string tag;
  } exp_t;

  logic             clk_in = 1'b0;
  logic             resetn = 1'b0;
  logic             locked = 1'b0;
  logic             pll_rst_req;
  logic             core_rst_n;
  logic             periph_rst_n;
  logic             ready;
  logic [CNT_W-1:0] loss_count;
  logic             lock_timeout;

  exp_t exp_q[$];
  exp_t mon_e;
  int   edge_no = 0;
  int   checks  = 0;
  int   errors  = 0;
  int   t;
  int   p;
  int   r;
  int   w;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES    (8),
    .LOCK_STABLE_CYCLES(16),
    .STAGE_GAP         (4),
    .LOCK_TIMEOUT      (64),
    .CNT_W             (CNT_W)
  ) dut (
    .clk_in      (clk_in),
    .resetn      (resetn),
    .locked      (locked),
    .pll_rst_req (pll_rst_req),
    .core_rst_n  (core_rst_n),
    .periph_rst_n(periph_rst_n),
    .ready       (ready),
    .loss_count  (loss_count),
    .lock_timeout(lock_timeout)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) edge_no <= edge_no + 1;

  // Queue an expected output snapshot (derived from the named state) for edge cyc.
  task automatic push_state(input int cyc, input int st, input int lc, input logic lto,
                            input string tag);
    exp_t e;
    int   idx;
    e.cyc    = cyc;
    e.pll    = (st == S_PLL);
    e.core   = (st == S_REL) || (st == S_RUN);
    e.periph = (st == S_RUN);
    e.rdy    = (st == S_RUN);
    e.lc     = lc;
    e.lto    = lto;
    e.tag    = tag;
    idx      = exp_q.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].cyc > cyc) begin
        idx = i;
        break;
      end
    end
    exp_q.insert(idx, e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [CNT_W+4:0] act;
    logic [CNT_W+4:0] req;
    act = {pll_rst_req, core_rst_n, periph_rst_n, ready, loss_count, lock_timeout};
    req = {e.pll, e.core, e.periph, e.rdy, CNT_W'(e.lc), e.lto};
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s @edge %0d: got pll=%b core=%b periph=%b ready=%b loss=%0d to=%b, want pll=%b core=%b periph=%b ready=%b loss=%0d to=%b",
               e.tag, e.cyc, pll_rst_req, core_rst_n, periph_rst_n, ready, loss_count,
               lock_timeout, e.pll, e.core, e.periph, e.rdy, e.lc, e.lto);
    end
  endtask

  task automatic wait_edge(input int target);
    while (edge_no < target) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic applyStimulus(input int at_edge, input logic rst_v, input logic lock_v);
    wait_edge(at_edge);
    resetn = rst_v;
    locked = lock_v;
  endtask

  // Monitor: reset-ordering invariant every cycle, then any expectations due now.
  always @(negedge clk_in) begin
    if (edge_no >= 1) begin
      checks++;
      if ((core_rst_n === 1'b0) && (periph_rst_n === 1'b1)) begin
        errors++;
        $display("[TB] FAIL order_invariant @edge %0d: got core=%b periph=%b, want not (core=0 and periph=1)",
                 edge_no, core_rst_n, periph_rst_n);
      end
    end
    while ((exp_q.size() > 0) && (exp_q[0].cyc <= edge_no)) begin
      mon_e = exp_q.pop_front();
      if (mon_e.cyc < edge_no) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s: expectation for edge %0d missed, now edge %0d",
                 mon_e.tag, mon_e.cyc, edge_no);
      end else begin
        checkOutput(mon_e);
      end
    end
  end

  initial begin
    // Reset state
    wait_edge(3);
    push_state(3, S_PLL, 0, 1'b0, "reset_state");

    // Bring-up: lock arrives after edge 12 of the sequence
    t = edge_no;
    applyStimulus(t, 1'b1, 1'b0);
    push_state(t + 7,  S_PLL,  0, 1'b0, "pll_held");
    push_state(t + 8,  S_WAIT, 0, 1'b0, "pll_fall");
    push_state(t + 29, S_WAIT, 0, 1'b0, "core_not_yet");
    push_state(t + 30, S_REL,  0, 1'b0, "core_rise");
    push_state(t + 33, S_REL,  0, 1'b0, "periph_not_yet");
    push_state(t + 34, S_RUN,  0, 1'b0, "periph_rise");
    applyStimulus(t + 12, 1'b1, 1'b1);
    wait_edge(t + 40);

    // Loss in RUN and full re-sequence
    t = edge_no;
    push_state(t + 2,  S_RUN,  0, 1'b0, "loss_run_pre");
    push_state(t + 3,  S_PLL,  1, 1'b0, "loss_run");
    push_state(t + 10, S_PLL,  1, 1'b0, "loss_pll_held");
    push_state(t + 11, S_WAIT, 1, 1'b0, "loss_pll_fall");
    push_state(t + 29, S_WAIT, 1, 1'b0, "loss_core_not_yet");
    push_state(t + 30, S_REL,  1, 1'b0, "loss_core_rise");
    push_state(t + 34, S_RUN,  1, 1'b0, "loss_rerun");
    applyStimulus(t, 1'b1, 1'b0);
    applyStimulus(t + 12, 1'b1, 1'b1);
    wait_edge(t + 40);

    // Glitchy lock: high 10 cycles, low 1, high again
    t = edge_no;
    push_state(t + 3,  S_PLL,  2, 1'b0, "glitch_loss");
    push_state(t + 11, S_WAIT, 2, 1'b0, "glitch_wait");
    push_state(t + 30, S_WAIT, 2, 1'b0, "glitch_no_early");
    push_state(t + 40, S_WAIT, 2, 1'b0, "glitch_core_not_yet");
    push_state(t + 41, S_REL,  2, 1'b0, "glitch_core_rise");
    push_state(t + 44, S_REL,  2, 1'b0, "glitch_periph_not_yet");
    push_state(t + 45, S_RUN,  2, 1'b0, "glitch_run");
    applyStimulus(t, 1'b1, 1'b0);
    applyStimulus(t + 12, 1'b1, 1'b1);
    applyStimulus(t + 22, 1'b1, 1'b0);
    applyStimulus(t + 23, 1'b1, 1'b1);
    wait_edge(t + 50);

    // Loss landing on the same edge as the stage-gap expiry in REL_CORE
    t = edge_no;
    push_state(t + 3,  S_PLL,  3, 1'b0, "rel_prep_loss");
    push_state(t + 30, S_REL,  3, 1'b0, "rel_entered");
    push_state(t + 33, S_REL,  3, 1'b0, "rel_last_gap");
    push_state(t + 34, S_PLL,  4, 1'b0, "rel_loss_priority");
    push_state(t + 35, S_PLL,  4, 1'b0, "rel_no_periph");
    push_state(t + 41, S_PLL,  4, 1'b0, "rel_pll_held");
    push_state(t + 42, S_WAIT, 4, 1'b0, "rel_pll_fall");
    applyStimulus(t, 1'b1, 1'b0);
    applyStimulus(t + 12, 1'b1, 1'b1);
    applyStimulus(t + 31, 1'b1, 1'b0);
    wait_edge(t + 42);

    // Twenty further losses in REL_CORE: loss_count saturates at 15
    p = edge_no;
    for (int i = 0; i < 20; i++) begin
      push_state(p + 18, S_REL,  (4 + i > 15) ? 15 : 4 + i, 1'b0, "sat_rel");
      push_state(p + 21, S_PLL,  (5 + i > 15) ? 15 : 5 + i, 1'b0, "sat_loss");
      push_state(p + 29, S_WAIT, (5 + i > 15) ? 15 : 5 + i, 1'b0, "sat_wait");
      applyStimulus(p, 1'b1, 1'b1);
      applyStimulus(p + 18, 1'b1, 1'b0);
      wait_edge(p + 29);
      p = p + 29;
    end

    // Mid-sequence reset during WAIT_LOCK, then during RUN
    p = edge_no;
    applyStimulus(p, 1'b1, 1'b1);
    push_state(p + 5, S_WAIT, 15, 1'b0, "pre_rst_wait");
    push_state(p + 6, S_PLL,  0,  1'b0, "rst_in_wait");
    applyStimulus(p + 5, 1'b0, 1'b1);
    applyStimulus(p + 7, 1'b1, 1'b1);
    r = p + 7;
    push_state(r + 7,  S_PLL,  0, 1'b0, "post_rst_pll");
    push_state(r + 8,  S_WAIT, 0, 1'b0, "post_rst_wait");
    push_state(r + 24, S_REL,  0, 1'b0, "post_rst_core");
    push_state(r + 28, S_RUN,  0, 1'b0, "post_rst_run");
    push_state(r + 30, S_RUN,  0, 1'b0, "pre_rst_run");
    push_state(r + 31, S_PLL,  0, 1'b0, "rst_in_run");
    applyStimulus(r + 30, 1'b0, 1'b1);

    // Watchdog: lock never arrives
    w = r + 32;
    applyStimulus(w, 1'b1, 1'b0);
    push_state(w + 8,  S_WAIT, 0, 1'b0, "wd_wait");
    push_state(w + 71, S_WAIT, 0, 1'b0, "wd_last_wait");
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
    push_state(w + 72,  S_PLL,  0, 1'b1, "wd_repulse");
    push_state(w + 79,  S_PLL,  0, 1'b1, "wd_pulse_held");
    push_state(w + 80,  S_WAIT, 0, 1'b1, "wd_pulse_end");
    push_state(w + 150, S_PLL,  0, 1'b1, "wd_sticky");
`else
    push_state(w + 72,  S_WAIT, 0, 1'b0, "no_repulse");
    push_state(w + 80,  S_WAIT, 0, 1'b0, "no_repulse_late");
    push_state(w + 150, S_WAIT, 0, 1'b0, "no_timeout_flag");
`endif
    wait_edge(w + 154);

    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL %s: expectation for edge %0d never compared", mon_e.tag, mon_e.cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
